// File: rtl/nn_classifier_core.sv
// rtl/nn_classifier_core.sv - binary-weight row-streaming classifier with argmax
module nn_classifier_core #(
  parameter int ROW_W   = 7,
  parameter int ROWS    = 28,
  parameter int CLASSES = 10,
  parameter logic [CLASSES*ROWS*ROW_W-1:0] WEIGHTS = '0,
  localparam int SCORE_W = $clog2(ROWS*ROW_W+1)+1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      abort,
  input  logic [ROW_W-1:0]          row_data,
  input  logic                      row_valid,
  output logic                      row_ready,
  output logic [3:0]                class_idx,
  output logic signed [SCORE_W-1:0] class_score,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic                      busy
);

  localparam int RC_W = (ROWS > 1) ? $clog2(ROWS) : 1;

  // Class index is a 4-bit output, so more than 16 classes cannot be represented.
  generate
    if (CLASSES < 2 || CLASSES > 16) begin : g_bad_classes
      $error("nn_classifier_core: CLASSES must be in 2..16");
    end
  endgenerate

  typedef enum logic [1:0] {LOAD, ARGMAX, DONE} state_t;

  state_t                    state;
  state_t                    state_next;
  logic [RC_W-1:0]           row_cnt;
  logic [3:0]                arg_cnt;
  logic signed [SCORE_W-1:0] acc   [CLASSES];
  logic signed [SCORE_W-1:0] delta [CLASSES];
  logic [ROW_W-1:0]          w_mem [CLASSES][ROWS];
  logic signed [SCORE_W-1:0] best_score;
  logic [3:0]                best_idx;
  logic signed [SCORE_W-1:0] cand_score;
  logic signed [SCORE_W-1:0] win_score;
  logic [3:0]                win_idx;
  logic                      take_new;
  logic                      row_accept;
  logic                      row_last;
  logic                      arg_last;

  // Unpack the flat weight parameter into a class/row table of row masks.
  for (genvar c = 0; c < CLASSES; c++) begin : g_wc
    for (genvar r = 0; r < ROWS; r++) begin : g_wr
      assign w_mem[c][r] = WEIGHTS[(c*ROWS + r)*ROW_W +: ROW_W];
    end
  end

  assign row_ready  = (state == LOAD);
  assign busy       = (state != LOAD);
  assign row_accept = row_valid && row_ready && !abort;
  assign row_last   = (row_cnt == RC_W'(ROWS-1));
  assign arg_last   = (arg_cnt == 4'(CLASSES-1));

  // Per-class score contribution of the current row: +1 per set pixel on a +1 weight, -1 on a -1 weight.
  always_comb begin
    for (int c = 0; c < CLASSES; c++) begin
      delta[c] = '0;
      for (int b = 0; b < ROW_W; b++) begin
        if (row_data[b]) begin
          if (w_mem[c][row_cnt][b]) delta[c] = delta[c] + SCORE_W'(1);
          else                      delta[c] = delta[c] - SCORE_W'(1);
        end
      end
    end
  end

  // Running argmax step: class 0 seeds the candidate, later classes win only when strictly greater.
  always_comb begin
    cand_score = acc[arg_cnt];
    take_new   = (arg_cnt == 4'd0) || (cand_score > best_score);
    win_idx    = take_new ? arg_cnt : best_idx;
    win_score  = take_new ? cand_score : best_score;
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= LOAD;
    else     state <= state_next;
  end

  // Next-state logic; abort overrides every transition.
  always_comb begin
    state_next = state;
    if (abort) begin
      state_next = LOAD;
    end else begin
      case (state)
        LOAD:    if (row_valid && row_last) state_next = ARGMAX;
        ARGMAX:  if (arg_last)              state_next = DONE;
        DONE:    if (out_ready)             state_next = LOAD;
        default:                            state_next = LOAD;
      endcase
    end
  end

  // Datapath: accumulate rows, scan classes, hold the result until it is taken.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int c = 0; c < CLASSES; c++) acc[c] <= '0;
      row_cnt     <= '0;
      arg_cnt     <= '0;
      best_idx    <= '0;
      best_score  <= '0;
      class_idx   <= '0;
      class_score <= '0;
      out_valid   <= 1'b0;
    end else if (abort) begin
      for (int c = 0; c < CLASSES; c++) acc[c] <= '0;
      row_cnt   <= '0;
      arg_cnt   <= '0;
      out_valid <= 1'b0;
    end else begin
      case (state)
        LOAD: begin
          if (row_accept) begin
            for (int c = 0; c < CLASSES; c++) acc[c] <= acc[c] + delta[c];
            row_cnt <= row_last ? '0 : row_cnt + RC_W'(1);
            arg_cnt <= '0;
          end
        end
        ARGMAX: begin
          best_idx   <= win_idx;
          best_score <= win_score;
          arg_cnt    <= arg_last ? 4'd0 : arg_cnt + 4'd1;
          if (arg_last) begin
            class_idx   <= win_idx;
            class_score <= win_score;
            out_valid   <= 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            for (int c = 0; c < CLASSES; c++) acc[c] <= '0;
            row_cnt   <= '0;
            out_valid <= 1'b0;
          end
        end
        default: begin
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_nn_classifier_core.sv
// tb/tb_nn_classifier_core.sv - scoreboard bench for nn_classifier_core
module tb_nn_classifier_core;

  localparam int ROW_W   = 7;
  localparam int ROWS    = 28;
  localparam int CLASSES = 10;
  localparam int WW      = CLASSES*ROWS*ROW_W;
  localparam int SCORE_W = $clog2(ROWS*ROW_W+1)+1;

  typedef logic [ROW_W-1:0] img_t [ROWS];

  function automatic logic [WW-1:0] make_weights();
    logic [WW-1:0] w;
    w = '0;
    for (int c = 0; c < CLASSES; c++)
      for (int b = 0; b < ROW_W; b++)
        w[c*ROWS*ROW_W + c*ROW_W + b] = 1'b1;
    return w;
  endfunction

  localparam logic [WW-1:0] TEST_W = make_weights();

  logic                      clk;
  logic                      rst;
  logic                      abort;
  logic [ROW_W-1:0]          row_data;
  logic                      row_valid;
  logic                      row_ready;
  logic [3:0]                class_idx;
  logic signed [SCORE_W-1:0] class_score;
  logic                      out_valid;
  logic                      out_ready;
  logic                      busy;

  int checks   = 0;
  int failures = 0;
  int exp_idx_q [$];
  int exp_sc_q  [$];

  nn_classifier_core #(
    .ROW_W(ROW_W), .ROWS(ROWS), .CLASSES(CLASSES), .WEIGHTS(TEST_W)
  ) dut (
    .clk(clk), .rst(rst), .abort(abort), .row_data(row_data), .row_valid(row_valid),
    .row_ready(row_ready), .class_idx(class_idx), .class_score(class_score),
    .out_valid(out_valid), .out_ready(out_ready), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: pixel in row c counts +1 for class c and -1 for all other classes.
  task automatic push_expected(input img_t img);
    int best_sc;
    int best_i;
    int s;
    best_sc = -100000;
    best_i  = 0;
    for (int c = 0; c < CLASSES; c++) begin
      s = 0;
      for (int r = 0; r < ROWS; r++)
        for (int b = 0; b < ROW_W; b++)
          if (img[r][b]) s += (r == c) ? 1 : -1;
      if (s > best_sc) begin
        best_sc = s;
        best_i  = c;
      end
    end
    exp_idx_q.push_back(best_i);
    exp_sc_q.push_back(best_sc);
  endtask

  task automatic drive_rows(input img_t img, input int start);
    for (int r = start; r < ROWS; r++) begin
      @(negedge clk);
      row_data  = img[r];
      row_valid = 1'b1;
    end
    @(negedge clk);
    row_valid = 1'b0;
    row_data  = '0;
  endtask

  task automatic send_image(input img_t img);
    push_expected(img);
    drive_rows(img, 0);
  endtask

  task automatic collect(output logic seen, output int lat, output int got_idx,
                         output int got_sc, output int exp_idx, output int exp_sc);
    lat = 0;
    while (out_valid !== 1'b1 && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    seen    = (out_valid === 1'b1);
    got_idx = int'(class_idx);
    got_sc  = int'($signed(class_score));
    exp_idx = -1;
    exp_sc  = -9999;
    if (seen && exp_idx_q.size() > 0) begin
      exp_idx = exp_idx_q.pop_front();
      exp_sc  = exp_sc_q.pop_front();
    end
  endtask

  task automatic release_result();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; abort = 1'b0; row_valid = 1'b0; row_data = '0; out_ready = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || row_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_ctrl got out_valid=%b busy=%b row_ready=%b required 0 0 1", out_valid, busy, row_ready);
    end
    checks++;
    if (class_idx !== 4'd0 || class_score !== '0) begin
      failures++;
      $display("FAIL reset_result got idx=%0d score=%0d required 0 0", class_idx, class_score);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_patterns();
    img_t img;
    logic seen;
    int lat, gi, gs, ei, es;
    for (int k = 0; k < 5; k++) begin
      for (int r = 0; r < ROWS; r++) img[r] = '0;
      case (k)
        1: img[5] = 7'h7F;
        2: begin img[2] = 7'h7F; img[7] = 7'h7F; end
        3: for (int r = 0; r < ROWS; r++) img[r] = 7'($urandom);
        4: for (int r = 0; r < 12; r++) img[r] = 7'($urandom);
        default: ;
      endcase
      send_image(img);
      collect(seen, lat, gi, gs, ei, es);
      checks++;
      if (!seen || lat != CLASSES) begin
        failures++;
        $display("FAIL pattern%0d_latency got seen=%b lat=%0d required 1 %0d", k, seen, lat, CLASSES);
      end
      checks++;
      if (gi != ei || gs != es) begin
        failures++;
        $display("FAIL pattern%0d_result got idx=%0d score=%0d required idx=%0d score=%0d", k, gi, gs, ei, es);
      end
      if (k == 0) begin
        checks++;
        if (ei != 0 || es != 0) begin
          failures++;
          $display("FAIL zero_model got idx=%0d score=%0d required 0 0", ei, es);
        end
      end
      if (k == 2) begin
        checks++;
        if (gi != 2 || gs != 0) begin
          failures++;
          $display("FAIL tie_result got idx=%0d score=%0d required 2 0", gi, gs);
        end
      end
      release_result();
      checks++;
      if (out_valid !== 1'b0 || row_ready !== 1'b1) begin
        failures++;
        $display("FAIL pattern%0d_release got out_valid=%b row_ready=%b required 0 1", k, out_valid, row_ready);
      end
    end
  endtask

  task automatic test_hold();
    img_t img;
    logic seen;
    int lat, gi, gs, ei, es;
    int bad;
    for (int r = 0; r < ROWS; r++) img[r] = '0;
    img[9] = 7'h7F;
    send_image(img);
    collect(seen, lat, gi, gs, ei, es);
    checks++;
    if (!seen || gi != 9 || gs != 7) begin
      failures++;
      $display("FAIL hold_result got seen=%b idx=%0d score=%0d required 1 9 7", seen, gi, gs);
    end
    row_valid = 1'b1;
    row_data  = 7'h7F;
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (row_ready !== 1'b0 || out_valid !== 1'b1 || busy !== 1'b1 ||
          int'(class_idx) != 9 || int'($signed(class_score)) != 7) bad++;
    end
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL hold_stable got %0d unstable cycles required 0", bad);
    end
    row_valid = 1'b0;
    row_data  = '0;
    release_result();
    checks++;
    if (out_valid !== 1'b0 || row_ready !== 1'b1 || busy !== 1'b0) begin
      failures++;
      $display("FAIL hold_release got out_valid=%b row_ready=%b busy=%b required 0 1 0", out_valid, row_ready, busy);
    end
  endtask

  task automatic test_abort();
    img_t img;
    logic seen;
    int lat, gi, gs, ei, es;
    for (int r = 0; r < 12; r++) begin
      @(negedge clk);
      row_data  = 7'h7F;
      row_valid = 1'b1;
    end
    @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort     = 1'b0;
    row_valid = 1'b0;
    row_data  = '0;
    for (int r = 0; r < ROWS; r++) img[r] = '0;
    img[5] = 7'h7F;
    send_image(img);
    collect(seen, lat, gi, gs, ei, es);
    checks++;
    if (!seen || lat != CLASSES) begin
      failures++;
      $display("FAIL abort_latency got seen=%b lat=%0d required 1 %0d", seen, lat, CLASSES);
    end
    checks++;
    if (gi != 5 || gs != 7) begin
      failures++;
      $display("FAIL abort_result got idx=%0d score=%0d required 5 7", gi, gs);
    end
    release_result();
  endtask

  task automatic test_reset_argmax();
    img_t img;
    logic seen;
    int lat, gi, gs, ei, es;
    int stale;
    for (int r = 0; r < ROWS; r++) img[r] = '0;
    img[3] = 7'h7F;
    drive_rows(img, 0);
    repeat (4) @(negedge clk);
    rst = 1'b1;
    #1;
    checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || row_ready !== 1'b1 ||
        class_idx !== 4'd0 || class_score !== '0) begin
      failures++;
      $display("FAIL rst_argmax got out_valid=%b busy=%b row_ready=%b idx=%0d score=%0d required 0 0 1 0 0",
               out_valid, busy, row_ready, class_idx, class_score);
    end
    @(negedge clk);
    rst = 1'b0;
    stale = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (out_valid !== 1'b0) stale++;
    end
    checks++;
    if (stale != 0) begin
      failures++;
      $display("FAIL rst_stale got %0d cycles with out_valid required 0", stale);
    end
    for (int r = 0; r < ROWS; r++) img[r] = '0;
    img[7] = 7'h7F;
    send_image(img);
    collect(seen, lat, gi, gs, ei, es);
    checks++;
    if (!seen || gi != 7 || gs != 7) begin
      failures++;
      $display("FAIL rst_next got seen=%b idx=%0d score=%0d required 1 7 7", seen, gi, gs);
    end
    release_result();
  endtask

  task automatic test_back_to_back();
    img_t a, b;
    logic seen;
    int lat, gi, gs, ei, es;
    for (int r = 0; r < ROWS; r++) begin
      a[r] = 7'($urandom);
      b[r] = 7'($urandom);
    end
    a[1] = 7'h7F;
    send_image(a);
    collect(seen, lat, gi, gs, ei, es);
    checks++;
    if (!seen || gi != ei || gs != es) begin
      failures++;
      $display("FAIL b2b_first got seen=%b idx=%0d score=%0d required idx=%0d score=%0d", seen, gi, gs, ei, es);
    end
    push_expected(b);
    out_ready = 1'b1;
    row_valid = 1'b1;
    row_data  = b[0];
    @(negedge clk);
    out_ready = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || row_ready !== 1'b1) begin
      failures++;
      $display("FAIL b2b_handshake got out_valid=%b row_ready=%b required 0 1", out_valid, row_ready);
    end
    drive_rows(b, 1);
    collect(seen, lat, gi, gs, ei, es);
    checks++;
    if (!seen || lat != CLASSES || gi != ei || gs != es) begin
      failures++;
      $display("FAIL b2b_second got seen=%b lat=%0d idx=%0d score=%0d required lat=%0d idx=%0d score=%0d",
               seen, lat, gi, gs, CLASSES, ei, es);
    end
    release_result();
    checks++;
    if (exp_idx_q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain got %0d pending required 0", exp_idx_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_patterns();
    test_hold();
    test_abort();
    test_reset_argmax();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog got timeout required completion");
    $fatal(1, "watchdog");
  end

endmodule
